// File: rtl/rotsq_button_ctrl.sv
// rotsq_button_ctrl
// Turns two raw pushbuttons into clean control levels for the rotating-square
// block. Each button passes through a two-flop synchronizer and then its own
// debounce FSM (ZERO / WAIT1 / ONE / WAIT0) with a DB_BITS-bit stability
// counter. A new level is accepted only after 2^DB_BITS+1 consecutive
// synchronized samples at that level. Each accepted press produces a one-cycle
// tick, and each tick toggles the matching output level.
//
// Parameters
//   DB_BITS    debounce counter width; stable window = 2^DB_BITS clocks
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   btn_pause  raw pushbutton (1 = pressed), toggles en
//   btn_dir    raw pushbutton (1 = pressed), toggles cw
//   en         registered rotation enable
//   cw         registered rotation direction (1 = clockwise)
//   pause_tick one-cycle pulse per accepted btn_pause press
//   dir_tick   one-cycle pulse per accepted btn_dir press
//
// Configuration macro
//   ROTSQ_DIR_HOLD_EN  when defined, dir_tick toggles cw only while en = 1
//                      (dir_tick itself still pulses). When undefined,
//                      dir_tick toggles cw regardless of en.

module rotsq_button_ctrl #(
    parameter int DB_BITS = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_pause,
    input  logic btn_dir,
    output logic en,
    output logic cw,
    output logic pause_tick,
    output logic dir_tick
);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } db_state_e;

    localparam logic [DB_BITS-1:0] CNT_MAX = '1;

    // Bit 0 carries btn_pause, bit 1 carries btn_dir throughout.
    logic [1:0] btn_raw;
    logic [1:0] sync1_q, sync1_d;
    logic [1:0] sync2_q, sync2_d;

    db_state_e          state_q [2];
    db_state_e          state_d [2];
    logic [DB_BITS-1:0] cnt_q   [2];
    logic [DB_BITS-1:0] cnt_d   [2];

    logic [1:0] tick_q, tick_d;
    logic       en_q, en_d;
    logic       cw_q, cw_d;

    assign btn_raw = {btn_dir, btn_pause};

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;

        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            tick_d[i]  = 1'b0;

            case (state_q[i])
                ZERO: begin
                    if (sync2_q[i]) begin
                        state_d[i] = WAIT1;
                        cnt_d[i]   = '0;
                    end
                end
                WAIT1: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = ZERO;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        // Only the WAIT1->ONE entry counts as a press; a
                        // WAIT0->ONE bounce back is deliberately silent.
                        state_d[i] = ONE;
                        cnt_d[i]   = '0;
                        tick_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + DB_BITS'(1);
                    end
                end
                ONE: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = WAIT0;
                        cnt_d[i]   = '0;
                    end
                end
                WAIT0: begin
                    if (sync2_q[i]) begin
                        state_d[i] = ONE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = ZERO;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + DB_BITS'(1);
                    end
                end
                default: begin
                    state_d[i] = ZERO;
                    cnt_d[i]   = '0;
                end
            endcase
        end

        // Outputs toggle on the edge that samples the registered tick.
        en_d = en_q ^ tick_q[0];
`ifdef ROTSQ_DIR_HOLD_EN
        // en_q is the pre-toggle value, so a simultaneous pause press
        // does not enable a direction change on the same edge.
        cw_d = cw_q ^ (tick_q[1] & en_q);
`else
        cw_d = cw_q ^ tick_q[1];
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= ZERO;
                cnt_q[i]   <= '0;
            end
            tick_q <= 2'b00;
            en_q   <= 1'b0;
            cw_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            tick_q <= tick_d;
            en_q   <= en_d;
            cw_q   <= cw_d;
        end
    end

    assign en         = en_q;
    assign cw         = cw_q;
    assign pause_tick = tick_q[0];
    assign dir_tick   = tick_q[1];

endmodule

// File: doc/rotsq_button_ctrl.md
ROTSQ_BUTTON_CTRL -- requirements
Module: rotsq_button_ctrl

Interface
REQ-001 Parameter: DB_BITS, default 20, debounce counter width; stable window = 2^DB_BITS clocks (~10.5 ms at 100 MHz).
REQ-002 clk  input  1  system clock; all flops on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 btn_pause  input  1  raw asynchronous pushbutton, high = pressed; toggles rotation enable.
REQ-005 btn_dir  input  1  raw asynchronous pushbutton, high = pressed; toggles rotation direction.
REQ-006 en  output  1  registered rotation enable, drives the rotating-square en input.
REQ-007 cw  output  1  registered direction, 1 = clockwise, drives the rotating-square cw input.
REQ-008 pause_tick  output  1  registered one-cycle pulse on each accepted debounced press of btn_pause.
REQ-009 dir_tick  output  1  registered one-cycle pulse on each accepted debounced press of btn_dir.

Function
REQ-010 Each button SHALL pass through a two-flop synchronizer before any other logic.
REQ-011 Each button SHALL have an independent debounce FSM, states ZERO, WAIT1, ONE, WAIT0, and its own DB_BITS-bit counter.
REQ-012 ZERO: sync=1 -> WAIT1, counter cleared; else stay.
REQ-013 WAIT1: sync=0 -> ZERO, counter cleared; sync=1 and counter<max -> counter+1; sync=1 and counter=max -> ONE, counter cleared.
REQ-014 ONE: sync=0 -> WAIT0, counter cleared; else stay.
REQ-015 WAIT0: sync=1 -> ONE, counter cleared; sync=0 and counter<max -> counter+1; sync=0 and counter=max -> ZERO, counter cleared.
REQ-016 The tick output SHALL be high for exactly the one cycle following the edge at which the FSM enters ONE; no tick on release or on a WAIT0->ONE bounce.
REQ-017 With raw input first sampled high at edge k and held, the FSM SHALL enter ONE at edge k+2+2^DB_BITS, tick high until edge k+3+2^DB_BITS.
REQ-018 en SHALL toggle at the edge on which pause_tick is sampled high (edge k+3+2^DB_BITS); cw likewise on dir_tick.
REQ-019 A pulse shorter than 2^DB_BITS+1 synchronized cycles SHALL produce no tick and no output change.
REQ-020 Holding a button indefinitely SHALL produce exactly one tick; re-trigger requires a full debounced release.
REQ-021 Simultaneous ticks on both buttons SHALL toggle en and cw on the same edge, independently.
REQ-022 Counter SHALL never wrap; max = all ones is terminal within WAIT1/WAIT0.

Reset
REQ-023 reset_n low SHALL immediately force en=0, cw=0, pause_tick=0, dir_tick=0, synchronizers 0, both FSMs ZERO, counters 0, regardless of clk.
REQ-024 Reset mid-debounce SHALL discard the in-progress press; a button held through reset release SHALL be debounced afresh and produce one tick.

Configuration
REQ-025 Macro ROTSQ_DIR_HOLD_EN: when defined, dir_tick SHALL toggle cw only when en=1 (dir_tick still pulses); when undefined, dir_tick toggles cw regardless of en.

Verification (DB_BITS=4, window 16 clocks)
REQ-026 Reset: reset_n=0 with buttons held high -> en=0, cw=0, ticks 0 throughout; after release one pause_tick, en=1.
REQ-027 Clean press: btn_pause high 40 clocks from edge k -> pause_tick high only between edges k+18 and k+19, en 0->1 at edge k+19; second identical press -> en 1->0.
REQ-028 Glitch: btn_dir high 10 clocks, then low -> no dir_tick, cw stays 0; bounce pattern 3 high/2 low x4 then steady high 30 -> exactly one dir_tick.
REQ-029 Hold: btn_pause high 500 clocks -> exactly one pause_tick; release 5 clocks then high 30 -> no new tick (WAIT0->ONE).
REQ-030 Simultaneous: both buttons rise same edge from en=1,cw=0 -> both ticks same cycle, en=0 and cw=1 same edge (macro undefined); with ROTSQ_DIR_HOLD_EN defined and en=0 before press, cw stays 0.
REQ-031 Mid-operation reset: reset_n low at clock 10 of WAIT1 -> all outputs 0 immediately, no tick; button still high after release -> tick 2^4+3 clocks later.
